// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   state_t      : responder FSM states (IDLE, BUSY, RESP)
//   IMEM_WORD_W  : width of one stored instruction word
//   addr_ok()    : aligned / not-below-base / in-range check, used by the
//                  fetch request path and by the load port
//   word_index() : byte address to word index relative to the base address
package imem_pkg;

  localparam int IMEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The subtraction is done one bit wider so the borrow flags addresses
  // that sit below the base.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] depth);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && !diff[32] && ({2'b00, diff[31:2]} < depth);
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/imem_array.sv
// Synchronous word store: one registered read port and one write port.
// A read and a write to the same word on one edge return the old word.
//   clk        : clock
//   rd_en_i    : capture mem[rd_idx_i] into rd_data_o at the edge
//   rd_idx_i   : read word index
//   rd_data_o  : registered read data, held until the next read
//   wr_en_i    : write wr_data_i to mem[wr_idx_i] at the edge
//   wr_idx_i   : write word index
//   wr_data_i  : write data
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                   clk,
  input  logic                   rd_en_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [IMEM_WORD_W-1:0] rd_data_o,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [IMEM_WORD_W-1:0] wr_data_i
);

  logic [IMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [IMEM_WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves word reads to the fetch stage over a
// valid/ready request/response handshake, one request outstanding, with a
// fixed read latency of LATENCY cycles and flush for pipeline redirects.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_addr  : fetch request (byte address)
//   req_ready           : request accepted at this edge if valid and ready
//   flush               : drop any in-flight request or pending response
//   resp_valid/_data/_addr/_err/_ready : response handshake
//   load_we/_addr/_data : word preload port (aligned, in-range only)
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..4");
  end

  state_t                 state_q;
  logic [1:0]             cnt_q;
  logic                   resp_valid_q;
  logic [31:0]            resp_addr_q;
  logic                   resp_err_q;
  logic                   data_ok_q;
  logic [IMEM_WORD_W-1:0] rd_data;

  logic             req_ok, load_ok, accept;
  logic [IDX_W-1:0] req_idx, load_idx;

  assign req_ok   = addr_ok(req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign load_ok  = addr_ok(load_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign req_idx  = IDX_W'(word_index(req_addr, BASE_ADDR));
  assign load_idx = IDX_W'(word_index(load_addr, BASE_ADDR));

  // Ready in IDLE, or in RESP when the pending response is being consumed.
  assign req_ready = !rst && !flush &&
                     ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk      (clk),
    .rd_en_i  (accept && req_ok),
    .rd_idx_i (req_idx),
    .rd_data_o(rd_data),
    .wr_en_i  (load_we && load_ok),
    .wr_idx_i (load_idx),
    .wr_data_i(load_data)
  );

  // The array output register only reloads on accept, so it already holds
  // the response word stable through BUSY and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      data_ok_q    <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      resp_valid_q <= 1'b0;
    end else if (accept) begin
      resp_addr_q <= req_addr;
      resp_err_q  <= !req_ok;
      data_ok_q   <= req_ok;
      if (LATENCY == 1) begin
        state_q      <= RESP;
        resp_valid_q <= 1'b1;
      end else begin
        state_q      <= BUSY;
        cnt_q        <= 2'(LATENCY - 1);
        resp_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == 2'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= 2'd0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_addr  = resp_addr_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = data_ok_q ? rd_data : 32'd0;

endmodule
